// File: rtl/tns_dec_arbiter.sv
// tns_dec_arbiter: round-robin front end that time-shares one combinational
// TNS decoder among NREQ lanes. The winning lane's code word is registered onto
// the decoder input, the decoder result is captured one cycle later, and the
// result is held on a valid/ready output tagged with the lane index.
module tns_dec_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 18,
  parameter int DW   = 18,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*CW-1:0] req_code,
  output logic [NREQ-1:0]    req_ready,
  output logic [CW-1:0]      dec_codein,
  input  logic [DW-1:0]      dec_dataout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [IW-1:0]      out_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_code;
  logic [IW-1:0]   r_id;
  logic [DW-1:0]   r_out_data;
  logic [IW-1:0]   r_out_id;
  logic            r_out_valid;

  logic            w_grant_en;
  logic            w_found;
  logic [IW-1:0]   w_gnt;
  logic            w_accept;
  logic [IW-1:0]   w_rr_next;

  // Grants are only possible when idle or when the held result leaves this cycle.
  assign w_grant_en = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);

  // Round-robin search starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = idx[IW-1:0];
      end
    end
  end

  assign w_accept  = w_grant_en && w_found;
  assign w_rr_next = (w_gnt == IW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

  // Accept strobe is masked during reset so no lane sees a spurious handshake.
  assign req_ready  = (w_accept && rst_n) ? (NREQ'(1) << w_gnt) : '0;
  assign dec_codein = r_code;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign busy       = (r_state != S_IDLE);

  // Sequencer: accept -> one decode cycle -> hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_code      <= '0;
      r_id        <= '0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_code   <= req_code[int'(w_gnt)*CW +: CW];
            r_id     <= w_gnt;
            r_rr_ptr <= w_rr_next;
            r_state  <= S_DEC;
          end
        end
        S_DEC: begin
          r_out_data  <= dec_dataout;
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_code   <= req_code[int'(w_gnt)*CW +: CW];
              r_id     <= w_gnt;
              r_rr_ptr <= w_rr_next;
              r_state  <= S_DEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tns_dec_arbiter.sv
// Directed bench for tns_dec_arbiter with an identity decoder stub.
module tb_tns_dec_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 18;
  localparam int DW   = 18;
  localparam int IW   = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_code;
  logic [NREQ-1:0]    req_ready;
  logic [CW-1:0]      dec_codein;
  logic [DW-1:0]      dec_dataout;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_id;
  logic               busy;

  int errors = 0;
  int checks = 0;

  tns_dec_arbiter #(.NREQ(NREQ), .CW(CW), .DW(DW), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .dec_codein (dec_codein),
    .dec_dataout(dec_dataout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
  );

  // Identity decoder stub
  assign dec_dataout = DW'(dec_codein);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int lane, input logic [CW-1:0] code);
    req_code[lane*CW +: CW] = code;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b0;
    #2;
    checks++;
    if ({req_ready, dec_codein, out_valid, out_data, out_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_low: got ready=%b codein=%h ov=%b data=%h id=%0d busy=%b, want all 0",
               req_ready, dec_codein, out_valid, out_data, out_id, busy);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({req_ready, dec_codein, out_valid, out_data, out_id, busy} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got ready=%b codein=%h ov=%b data=%h id=%0d busy=%b, want all 0",
                 i, req_ready, dec_codein, out_valid, out_data, out_id, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    set_code(2, 18'h2A5A5);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || dec_codein !== 18'h2A5A5) begin
      errors++;
      $display("FAIL single_dec: got ov=%b busy=%b codein=%h want ov=0 busy=1 codein=2a5a5",
               out_valid, busy, dec_codein);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'h2A5A5 || out_id !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got ov=%b data=%h id=%0d want ov=1 data=2a5a5 id=2",
               out_valid, out_data, out_id);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_all_lanes();
    do_reset();
    out_ready = 1'b1;
    for (int l = 0; l < NREQ; l++) set_code(l, 18'(1 << l));
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_first_ready: got %b want 0001", req_ready);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) req_valid = '0;
      checks++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_dec%0d: got ready=%b ov=%b want 0000 0", i, req_ready, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== IW'(i % 4) || out_data !== 18'(1 << (i % 4))) begin
        errors++;
        $display("FAIL rr_out%0d: got ov=%b id=%0d data=%h want ov=1 id=%0d data=%h",
                 i, out_valid, out_id, out_data, i % 4, 18'(1 << (i % 4)));
      end
      if (i < 7) begin
        checks++;
        if (req_ready !== 4'(1 << ((i + 1) % 4))) begin
          errors++;
          $display("FAIL rr_ready%0d: got %b want %b", i, req_ready, 4'(1 << ((i + 1) % 4)));
        end
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_drain: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    set_code(1, 18'h3FFFF);
    set_code(3, 18'h12345);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_ready1: got %b want 0010", req_ready);
    end
    step();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_dec_ready: got %b want 0000", req_ready);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'h3FFFF || out_id !== 2'd1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got ov=%b data=%h id=%0d ready=%b want 1 3ffff 1 0000",
                 i, out_valid, out_data, out_id, req_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1000", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b0 || dec_codein !== 18'h12345) begin
      errors++; $display("FAIL bp_next_dec: got ov=%b codein=%h want 0 12345", out_valid, dec_codein);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'h12345 || out_id !== 2'd3) begin
      errors++;
      $display("FAIL bp_next_out: got ov=%b data=%h id=%0d want 1 12345 3", out_valid, out_data, out_id);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    set_code(2, 18'h00222);
    set_code(0, 18'h0AAAA);
    set_code(3, 18'h15333);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    step();
    checks++;
    if (out_id !== 2'd2 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_first: got id=%0d ready=%b want 2 1000", out_id, req_ready);
    end
    step();
    req_valid = 4'b0001;
    step();
    checks++;
    if (out_data !== 18'h15333 || out_id !== 2'd3 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_second: got data=%h id=%0d ready=%b want 15333 3 0001", out_data, out_id, req_ready);
    end
    step();
    req_valid = '0;
    step();
    checks++;
    if (out_data !== 18'h0AAAA || out_id !== 2'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_third: got data=%h id=%0d ov=%b want 0aaaa 0 1", out_data, out_id, out_valid);
    end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    set_code(0, 18'h15555);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dec_codein !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL areset_clear: got ov=%b codein=%h busy=%b ready=%b want all 0",
               out_valid, dec_codein, busy, req_ready);
    end
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL areset_stale%0d: got ov=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL areset_represent: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'h15555 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL areset_result: got ov=%b data=%h id=%0d want 1 15555 0", out_valid, out_data, out_id);
    end
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_lanes();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
